// File: rtl/cp0_pkg.sv
// cp0_pkg: shared constants for the coprocessor-0 block.
//   - CP0 register numbers used by mfc0/mtc0
//   - exception codes produced by the pipeline
//   - bit-field positions of the SR and Cause registers
//   - helpers that assemble the architectural SR/Cause read views
`timescale 1ns/1ps
package cp0_pkg;

    // CP0 register numbers
    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    // Exception codes reported by the M stage (0 = no exception)
    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;

    // SR field positions
    localparam int unsigned SR_IM_HI = 15;
    localparam int unsigned SR_IM_LO = 10;
    localparam int unsigned SR_EXL   = 1;
    localparam int unsigned SR_IE    = 0;

    // Cause field positions
    localparam int unsigned CAUSE_BD     = 31;
    localparam int unsigned CAUSE_IP_HI  = 15;
    localparam int unsigned CAUSE_IP_LO  = 10;
    localparam int unsigned CAUSE_EXC_HI = 6;
    localparam int unsigned CAUSE_EXC_LO = 2;

    // Assemble the 32-bit SR view; unimplemented bits read as zero.
    function automatic logic [31:0] pack_sr(input logic [5:0] im,
                                            input logic       exl,
                                            input logic       ie);
        logic [31:0] v;
        v                   = '0;
        v[SR_IM_HI:SR_IM_LO] = im;
        v[SR_EXL]           = exl;
        v[SR_IE]            = ie;
        return v;
    endfunction

    // Assemble the 32-bit Cause view; unimplemented bits read as zero.
    function automatic logic [31:0] pack_cause(input logic       bd,
                                               input logic [5:0] ip,
                                               input logic [4:0] exc);
        logic [31:0] v;
        v                           = '0;
        v[CAUSE_BD]                 = bd;
        v[CAUSE_IP_HI:CAUSE_IP_LO]  = ip;
        v[CAUSE_EXC_HI:CAUSE_EXC_LO] = exc;
        return v;
    endfunction

endpackage

// File: rtl/cp0_ctrl.sv
// cp0_ctrl: coprocessor 0 for the 5-stage MIPS pipeline.
// Decides when to take an exception or interrupt, records the victim PC
// and cause, and serves mfc0/mtc0 accesses from the M stage.
//
// Ports:
//   clk      in   system clock, all state updates on posedge
//   reset    in   asynchronous active-low reset
//   A1       in   [4:0]  mfc0 read register number
//   A2       in   [4:0]  mtc0 write register number
//   DIn      in   [31:0] mtc0 write data
//   We       in   mtc0 write enable
//   PC       in   [31:0] PC of the M-stage (victim) instruction
//   BD       in   M-stage instruction sits in a branch delay slot
//   ExcCode  in   [4:0]  M-stage exception code, 0 = none
//   HWInt    in   [5:0]  level-sensitive hardware interrupt lines
//   EXLClr   in   ERET in M stage, clears SR.EXL
//   IntReq   out  take exception/interrupt this cycle
//   EPC      out  [31:0] current EPC register
//   DOut     out  [31:0] mfc0 read data (pre-update value)
`timescale 1ns/1ps
module cp0_ctrl
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID_VAL   = 32'h0000_4D4A,
    // Exception entry address; the fetch stage performs the redirect.
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [31:0] DIn,
    input  logic        We,
    input  logic [31:0] PC,
    input  logic        BD,
    input  logic [4:0]  ExcCode,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic        IntReq,
    output logic [31:0] EPC,
    output logic [31:0] DOut
);

    // SR fields
    logic [5:0]  sr_im;
    logic        sr_exl;
    logic        sr_ie;

    // Cause fields
    logic        cause_bd;
    logic [5:0]  cause_ip;
    logic [4:0]  cause_exc;

    logic [31:0] epc_q;

    logic        int_req;
    logic        exc_req;
    logic [31:0] pc_word;
    logic [31:0] victim_pc;

    // Request decision from current state and inputs
    always_comb begin
        int_req = (|(HWInt & sr_im)) & sr_ie & ~sr_exl;
        exc_req = (ExcCode != 5'd0) & ~sr_exl;
        IntReq  = int_req | exc_req;
    end

    // Victim PC: word-aligned, backed up one instruction for a delay slot
    // so the handler returns to the branch. The subtraction wraps.
    always_comb begin
        pc_word   = PC & 32'hFFFF_FFFC;
        victim_pc = BD ? (pc_word - 32'd4) : pc_word;
    end

    // Cause.IP tracks the raw lines every cycle, independent of masking.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cause_ip <= '0;
        end else begin
            cause_ip <= HWInt;
        end
    end

    // Exception entry has priority over mtc0/ERET; a colliding mtc0 is
    // dropped because the faulting instruction must not commit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_im     <= '0;
            sr_exl    <= 1'b0;
            sr_ie     <= 1'b0;
            cause_bd  <= 1'b0;
            cause_exc <= '0;
            epc_q     <= '0;
        end else if (IntReq) begin
            cause_exc <= int_req ? EXC_INT : ExcCode;
            cause_bd  <= BD;
            epc_q     <= victim_pc;
            sr_exl    <= 1'b1;
        end else begin
            if (We) begin
                case (A2)
                    REG_SR: begin
                        sr_im  <= DIn[SR_IM_HI:SR_IM_LO];
                        sr_exl <= DIn[SR_EXL];
                        sr_ie  <= DIn[SR_IE];
                    end
                    REG_EPC: epc_q <= DIn;
                    default: ;
                endcase
            end
            // Placed after the SR write so ERET wins for the EXL bit only.
            if (EXLClr) begin
                sr_exl <= 1'b0;
            end
        end
    end

    // mfc0 read path: current register contents, no write-through.
    always_comb begin
        case (A1)
            REG_SR:    DOut = pack_sr(sr_im, sr_exl, sr_ie);
            REG_CAUSE: DOut = pack_cause(cause_bd, cause_ip, cause_exc);
            REG_EPC:   DOut = epc_q;
            REG_PRID:  DOut = PRID_VAL;
            default:   DOut = '0;
        endcase
    end

    assign EPC = epc_q;

endmodule

// File: tb/tb_cp0_ctrl.sv
`timescale 1ns/1ps
module tb_cp0_ctrl;

    logic        clk;
    logic        reset;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] DIn;
    logic        We;
    logic [31:0] PC;
    logic        BD;
    logic [4:0]  ExcCode;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic        IntReq;
    logic [31:0] EPC;
    logic [31:0] DOut;

    int total;
    int bad;

    cp0_ctrl #(
        .PRID_VAL  (32'h0000_4D4A),
        .HANDLER_PC(32'h0000_4180)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .A1     (A1),
        .A2     (A2),
        .DIn    (DIn),
        .We     (We),
        .PC     (PC),
        .BD     (BD),
        .ExcCode(ExcCode),
        .HWInt  (HWInt),
        .EXLClr (EXLClr),
        .IntReq (IntReq),
        .EPC    (EPC),
        .DOut   (DOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] a, input string tag, input logic [31:0] exp);
        A1 = a;
        #1;
        check(tag, DOut, exp);
    endtask

    task automatic eret();
        EXLClr = 1'b1;
        step();
        EXLClr = 1'b0;
        #1;
    endtask

    initial begin
        total = 0; bad = 0;
        reset = 1'b0; A1 = 5'd12; A2 = 5'd12; DIn = 32'hFFFF_FFFF; We = 1'b1;
        PC = '0; BD = 1'b0; ExcCode = '0; HWInt = '0; EXLClr = 1'b0;

        // reset held with a pending SR write
        repeat (3) step();
        rd(5'd12, "sr_in_reset", 32'h0);
        reset = 1'b1; We = 1'b0;
        #1;
        rd(5'd12, "sr_after_reset", 32'h0);
        check("epc_after_reset", EPC, 32'h0);
        check("intreq_after_reset", {31'h0, IntReq}, 32'h0);

        // enable IM[10] and IE
        We = 1'b1; A2 = 5'd12; DIn = 32'h0000_0401;
        step();
        We = 1'b0;
        rd(5'd12, "sr_written", 32'h0000_0401);

        // interrupt entry
        HWInt = 6'b000001; PC = 32'h0000_3010; BD = 1'b0;
        #1;
        check("int_req_now", {31'h0, IntReq}, 32'h1);
        step();
        check("int_epc", EPC, 32'h0000_3010);
        rd(5'd13, "int_cause", 32'h0000_0400);
        rd(5'd12, "int_sr_exl", 32'h0000_0403);
        check("int_exl_blocks", {31'h0, IntReq}, 32'h0);

        // nested exception suppressed while EXL=1
        ExcCode = 5'd4;
        #1;
        check("exl_suppress", {31'h0, IntReq}, 32'h0);
        step();
        check("exl_epc_kept", EPC, 32'h0000_3010);
        ExcCode = 5'd0;

        // ERET with the line still unmasked: fires on the next cycle
        EXLClr = 1'b1;
        #1;
        check("eret_same_cycle", {31'h0, IntReq}, 32'h0);
        step();
        EXLClr = 1'b0;
        PC = 32'h0000_3040;
        #1;
        check("eret_refire", {31'h0, IntReq}, 32'h1);
        step();
        check("refire_epc", EPC, 32'h0000_3040);
        HWInt = '0;
        eret();

        // exception in a branch delay slot
        ExcCode = 5'd12; PC = 32'h0000_3024; BD = 1'b1;
        #1;
        check("ds_req", {31'h0, IntReq}, 32'h1);
        step();
        check("ds_epc", EPC, 32'h0000_3020);
        rd(5'd13, "ds_cause", 32'h8000_0030);
        ExcCode = 5'd0; BD = 1'b0;
        eret();

        // interrupt beats a simultaneous RI exception
        HWInt = 6'b000001; ExcCode = 5'd10; PC = 32'h0000_3100;
        step();
        rd(5'd13, "prio_cause", 32'h0000_0400);
        check("prio_epc", EPC, 32'h0000_3100);
        HWInt = '0; ExcCode = '0;
        eret();

        // all lines masked: no request, IP still visible
        We = 1'b1; A2 = 5'd12; DIn = 32'h0000_0001;
        step();
        We = 1'b0;
        HWInt = 6'b111111;
        #1;
        check("mask_no_req", {31'h0, IntReq}, 32'h0);
        step();
        rd(5'd13, "mask_ip", 32'h0000_FC00);
        HWInt = '0;

        // mtc0 to EPC dropped by a colliding AdES
        We = 1'b1; A2 = 5'd14; DIn = 32'h0000_5000; ExcCode = 5'd5; PC = 32'h0000_3008;
        #1;
        check("coll_req", {31'h0, IntReq}, 32'h1);
        step();
        We = 1'b0; ExcCode = '0;
        check("coll_epc", EPC, 32'h0000_3008);
        rd(5'd13, "coll_cause", 32'h0000_0014);
        eret();

        // plain mtc0 to EPC; read during the write sees the old value
        We = 1'b1; A2 = 5'd14; DIn = 32'h0000_5000;
        rd(5'd14, "epc_pre_update", 32'h0000_3008);
        step();
        check("epc_written", EPC, 32'h0000_5000);

        // Cause is read-only, PrID constant, unmapped reads 0
        A2 = 5'd13; DIn = 32'hFFFF_FFFF;
        step();
        We = 1'b0;
        rd(5'd13, "cause_ro", 32'h0000_0014);
        rd(5'd15, "prid", 32'h0000_4D4A);
        rd(5'd3, "unmapped", 32'h0);

        // SR write with EXL=1 plus ERET: EXL cleared, IM/IE written
        We = 1'b1; A2 = 5'd12; DIn = 32'h0000_FC03; EXLClr = 1'b1;
        step();
        We = 1'b0; EXLClr = 1'b0;
        rd(5'd12, "sr_eret_wins", 32'h0000_FC01);

        // delay-slot EPC wraps below zero
        ExcCode = 5'd12; BD = 1'b1; PC = 32'h0000_0002;
        step();
        check("epc_wrap", EPC, 32'hFFFF_FFFC);
        ExcCode = '0; BD = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cp0_ctrl.md
Name: cp0_ctrl

Overview:
- Coprocessor-0 for the 5-stage MIPS pipeline.
- Collects exception codes from the pipeline (including fetch PC-alignment/range faults) and the 6 hardware interrupt lines.
- Decides when to take an exception, records victim PC/cause, and drives IntReq and EPC back to the fetch stage for redirect (PC to 0x00004180) and ERET return.
- Services mfc0/mtc0 register accesses from the M stage.

Parameters:
- PRID_VAL, 32'h0000_4D4A: constant value returned for PrID (reg 15).
- HANDLER_PC, 32'h0000_4180: exception entry address; documentation only, since the fetch stage owns the redirect.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- A1  in  5  mfc0 read register number.
- A2  in  5  mtc0 write register number.
- DIn  in  32  mtc0 write data.
- We  in  1  mtc0 write enable.
- PC  in  32  PC of the instruction currently in M stage (victim).
- BD  in  1  M-stage instruction is in a branch delay slot.
- ExcCode  in  5  exception code from M stage; 0 = none.
- HWInt  in  6  external interrupt lines, level-sensitive.
- EXLClr  in  1  ERET in M stage.
- IntReq  out  1  take exception/interrupt this cycle.
- EPC  out  32  current EPC register.
- DOut  out  32  mfc0 read data.

Behaviour:
Registers:
- SR (12): IM[15:10], EXL[1], IE[0]; all other bits read 0.
- Cause (13): BD[31], IP[15:10], ExcCode[6:2]; read-only to mtc0.
- EPC (14): full 32 bits.
- PrID (15): PRID_VAL, read-only.
- Any other address reads 0; writes to it are ignored.

Reset (reset=0, asynchronous):
- SR=0, Cause=0, EPC=0. Outputs IntReq=0, EPC=0, DOut reflects zeroed registers.
- Deassertion is sampled synchronously; first update on the first posedge after release.

IntReq (combinational from current state and inputs):
- int_req = |(HWInt & SR.IM) & SR.IE & !SR.EXL
- exc_req = (ExcCode != 0) & !SR.EXL
- IntReq = int_req | exc_req

On posedge with IntReq=1 (interrupt has priority over exception):
- Cause.ExcCode <= int_req ? 0 : ExcCode.
- Cause.BD <= BD.
- EPC <= BD ? {PC[31:2],2'b00} - 4 : {PC[31:2],2'b00}. Subtraction is 32-bit and wraps.
- SR.EXL <= 1.
- Any mtc0 in the same cycle is dropped; the faulting instruction must not commit.

Cause.IP:
- Cause.IP <= HWInt every cycle regardless of masking or EXL, so pending lines stay visible.

On posedge with IntReq=0:
- If We, write the selected register: SR takes DIn[15:10], DIn[1], DIn[0]; EPC takes DIn.
- If EXLClr, SR.EXL <= 0.
- If We targets SR and EXLClr is asserted in the same cycle, EXLClr wins for the EXL bit only; IM and IE are still written.

While EXL=1:
- No new IntReq; nested exceptions are suppressed.
- A pending interrupt fires on the first cycle after EXL clears, provided IE=1 and the line is unmasked.

DOut:
- Combinational read of register A1.
- Reads return the pre-update value; no write-through bypass.
- A read of 13 returns live Cause, including IP for the current cycle.

EPC output:
- Registered value. The pipeline guarantees at least one cycle between an mtc0 to EPC and a dependent ERET.

Decomposition:
- Package cp0_pkg holds:
  - register numbers: SR=12, CAUSE=13, EPC=14, PRID=15;
  - ExcCode constants: INT=0, ADEL=4, ADES=5, RI=10, OV=12;
  - bit-field positions for SR and Cause.
- No sub-module needed; the single flat block is ~150–200 lines.

Test Plan:
- Reset: hold reset=0 with We=1, A2=12, DIn=32'hFFFF_FFFF → SR stays 0; after release, A1=12 gives DOut=0, EPC=0, IntReq=0.
- Interrupt:
  - Setup: mtc0 SR=32'h0000_0401 (IM[10]=1, IE=1); then HWInt=6'b000001, PC=32'h0000_3010, BD=0.
  - IntReq=1 same cycle.
  - Next cycle: EPC=32'h0000_3010, Cause.ExcCode=0, Cause.IP=6'b000001, SR.EXL=1, IntReq=0.
- Delay-slot exception: ExcCode=12, PC=32'h0000_3024, BD=1, EXL=0 → IntReq=1; next cycle EPC=32'h0000_3020, Cause=32'h8000_0030.
- Priority and masking:
  - Interrupt priority: HWInt unmasked and ExcCode=10 together → Cause.ExcCode=0.
  - Masking: with IM=0 and ExcCode=0, HWInt=6'b111111 → IntReq=0 and Cause.IP=6'b111111.
- EXL suppression and ERET:
  - With EXL=1, ExcCode=4 → IntReq=0, EPC unchanged.
  - Pulse EXLClr with HWInt still unmasked → the next cycle gives IntReq=1.
- mtc0 collision: We=1, A2=14, DIn=32'h0000_5000 while ExcCode=5, PC=32'h0000_3008 → EPC=32'h0000_3008 (write dropped); a write to 13 never changes Cause; A1=15 reads 32'h0000_4D4A.
